// File: rtl/ext_pkg.sv
// ext_pkg: mode encodings and sizing helper shared by the extension stage.
package ext_pkg;
    localparam int EXT_MODE_W = 3;
    localparam logic [EXT_MODE_W-1:0] EXT_ZEXT  = 3'd0;
    localparam logic [EXT_MODE_W-1:0] EXT_SEXT  = 3'd1;
    localparam logic [EXT_MODE_W-1:0] EXT_LUI   = 3'd2;
    localparam logic [EXT_MODE_W-1:0] EXT_SHAMT = 3'd3;
    localparam logic [EXT_MODE_W-1:0] EXT_LB    = 3'd4;
    localparam logic [EXT_MODE_W-1:0] EXT_LBU   = 3'd5;
    localparam logic [EXT_MODE_W-1:0] EXT_LH    = 3'd6;
    localparam logic [EXT_MODE_W-1:0] EXT_LHU   = 3'd7;

    function automatic int clog2(input int v);
        int r = 0;
        for (int i = 0; i < 31; i++) if ((1 << i) < v) r = i + 1;
        return r;
    endfunction
endpackage

// File: rtl/ext_comb.sv
// ext_comb: combinational immediate / load-data extension with alignment error.
module ext_comb
    import ext_pkg::*;
#(
    parameter int IN_W   = 16,
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0]     data_i,
    input  logic [EXT_MODE_W-1:0] mode_i,
    input  logic [1:0]            off_i,
    output logic [DATA_W-1:0]     result_o,
    output logic                  err_o
);
    logic [7:0]  byte_v;
    logic [15:0] half_v;

    assign byte_v = data_i[{off_i, 3'b000} +: 8];
    assign half_v = off_i[1] ? data_i[31:16] : data_i[15:0];

    always_comb begin
        result_o = '0;
        err_o    = 1'b0;
        case (mode_i)
            EXT_ZEXT:  result_o = DATA_W'(data_i[IN_W-1:0]);
            EXT_SEXT:  result_o = {{(DATA_W-IN_W){data_i[IN_W-1]}}, data_i[IN_W-1:0]};
            EXT_LUI:   result_o = DATA_W'({data_i[15:0], 16'h0000});
            EXT_SHAMT: result_o = DATA_W'(data_i[10:6]);
            EXT_LB:    result_o = {{(DATA_W-8){byte_v[7]}}, byte_v};
            EXT_LBU:   result_o = DATA_W'(byte_v);
            // mode_i[0] distinguishes LHU (zero) from LH (sign)
            EXT_LH, EXT_LHU: begin
                err_o    = off_i[0];
                result_o = off_i[0] ? '0 : {{(DATA_W-16){half_v[15] & ~mode_i[0]}}, half_v};
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/ext_stage.sv
// ext_stage: extension unit feeding a DEPTH-entry valid/ready FIFO;
// all outputs come from registered state.
module ext_stage
    import ext_pkg::*;
#(
    parameter int IN_W   = 16,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [DATA_W-1:0]     in_data_i,
    input  logic [EXT_MODE_W-1:0] in_mode_i,
    input  logic [1:0]            in_off_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [DATA_W-1:0]     out_data_o,
    output logic                  out_err_o,
    output logic [clog2(DEPTH):0] occupancy_o
);
    localparam int PW = clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [DATA_W:0]   mem_q [DEPTH];
    logic [DATA_W:0]   last_q, last_d;
    logic [PW-1:0]     wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [DATA_W-1:0] ext_data;
    logic              ext_err, push, pop;

    ext_comb #(.IN_W(IN_W), .DATA_W(DATA_W)) u_comb (
        .data_i   (in_data_i),
        .mode_i   (in_mode_i),
        .off_i    (in_off_i),
        .result_o (ext_data),
        .err_o    (ext_err)
    );

    assign in_ready_o  = cnt_q < CW'(DEPTH);
    assign out_valid_o = cnt_q != '0;
    assign occupancy_o = cnt_q;
    assign push        = in_valid_i & in_ready_o;
    assign pop         = out_valid_o & out_ready_i;
    // when empty the output keeps showing the most recently popped entry
    assign {out_err_o, out_data_o} = out_valid_o ? mem_q[rd_q] : last_q;

    always_comb begin
        wr_d   = push ? wr_q + 1'b1 : wr_q;
        rd_d   = pop ? rd_q + 1'b1 : rd_q;
        cnt_d  = cnt_q + CW'(push) - CW'(pop);
        last_d = pop ? mem_q[rd_q] : last_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            last_q <= '0;
            wr_q   <= '0;
            rd_q   <= '0;
            cnt_q  <= '0;
        end else begin
            if (push) mem_q[wr_q] <= {ext_err, ext_data};
            last_q <= last_d;
            wr_q   <= wr_d;
            rd_q   <= rd_d;
            cnt_q  <= cnt_d;
        end
    end
endmodule

// File: tb/tb_ext_stage.sv
// tb_ext_stage: scoreboard bench for ext_stage with an arithmetic reference model.
module tb_ext_stage;
    import ext_pkg::*;
    localparam int IN_W   = 16;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 2;
    localparam int CW     = clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [31:0]   in_data = '0;
    logic [2:0]    in_mode = '0;
    logic [1:0]    in_off = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [31:0]   out_data;
    logic          out_err;
    logic [CW-1:0] occupancy;

    logic [32:0] cur_exp = '0;
    logic [32:0] sb [$];
    logic [32:0] held = '0;
    bit          hold_v = 1'b0;
    int          n_cmp = 0, n_bad = 0, pushes = 0, pops = 0;

    logic [31:0] dv_data [11] = '{32'h0000_8001, 32'h0000_8001, 32'h80FF_7F01, 32'h80FF_7F01,
                                  32'h80FF_7F01, 32'h80FF_7F01, 32'h80FF_7F01, 32'h0000_1234,
                                  32'h0000_07C0, 32'h80FF_7F01, 32'h80FF_7F01};
    logic [2:0]  dv_mode [11] = '{3'd1, 3'd0, 3'd4, 3'd4, 3'd5, 3'd6, 3'd7, 3'd2, 3'd3, 3'd6, 3'd4};
    logic [1:0]  dv_off  [11] = '{2'd0, 2'd0, 2'd1, 2'd2, 2'd3, 2'd2, 2'd1, 2'd0, 2'd0, 2'd3, 2'd0};
    logic [32:0] dv_exp  [11] = '{{1'b0, 32'hFFFF_8001}, {1'b0, 32'h0000_8001}, {1'b0, 32'h0000_007F},
                                  {1'b0, 32'hFFFF_FFFF}, {1'b0, 32'h0000_0080}, {1'b0, 32'hFFFF_80FF},
                                  {1'b1, 32'h0000_0000}, {1'b0, 32'h1234_0000}, {1'b0, 32'h0000_001F},
                                  {1'b1, 32'h0000_0000}, {1'b0, 32'h0000_0001}};

    ext_stage #(.IN_W(IN_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_data_i   (in_data),
        .in_mode_i   (in_mode),
        .in_off_i    (in_off),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (out_data),
        .out_err_o   (out_err),
        .occupancy_o (occupancy)
    );

    always #5 clk = ~clk;

    function automatic logic [32:0] model(input logic [31:0] d, input logic [2:0] m, input logic [1:0] o);
        longint u = longint'(d);
        longint p = longint'(1) << IN_W;
        longint v = 0;
        bit     e = 1'b0;
        case (m)
            3'd0: v = u % p;
            3'd1: begin v = u % p; if (v >= p / 2) v -= p; end
            3'd2: v = (u % 65536) * 65536;
            3'd3: v = (u / 64) % 32;
            3'd4, 3'd5: begin
                v = (u >> (8 * o)) % 256;
                if (m == 3'd4 && v >= 128) v -= 256;
            end
            default: begin
                if (o % 2 == 1) begin v = 0; e = 1'b1; end
                else begin
                    v = (u >> (8 * o)) % 65536;
                    if (m == 3'd6 && v >= 32768) v -= 65536;
                end
            end
        endcase
        return {e, v[31:0]};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input string nm);
        int t = 0;
        while (!in_ready && t < 50) begin step(); t++; end
        if (!in_ready) begin
            n_cmp++; n_bad++;
            $display("FAIL %s: in_ready timeout got 0 expected 1", nm);
        end
    endtask

    task automatic send(input logic [31:0] d, input logic [2:0] m, input logic [1:0] o, input logic [32:0] e);
        in_valid = 1'b1; in_data = d; in_mode = m; in_off = o; cur_exp = e;
        wait_ready("send");
        step();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        in_valid = 1'b0; out_ready = 1'b1;
        while (sb.size() != 0 && t < 100) begin step(); t++; end
        step();
        chk("drain_empty", 64'(sb.size()), 0);
        chk("drain_out_valid", out_valid, 0);
    endtask

    // recorder: expected response enters the scoreboard when a request is accepted
    always @(negedge clk) begin
        if (rst_n && in_valid && in_ready) begin
            sb.push_back(cur_exp);
            pushes++;
        end
    end

    always @(negedge clk) begin
        if (!rst_n) hold_v = 1'b0;
        else begin
            if (hold_v && out_valid) chk("hold_stable", {out_err, out_data}, held);
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL unexpected_output: got %0h expected none", {out_err, out_data});
                end else chk("out", {out_err, out_data}, sb.pop_front());
                pops++;
            end
            hold_v = out_valid && !out_ready;
            held   = {out_err, out_data};
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        logic [31:0] d;
        step(); step();
        rst_n = 1'b1;
        step();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_occupancy", occupancy, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_data", {out_err, out_data}, 0);

        out_ready = 1'b1;
        for (int i = 0; i < 11; i++) send(dv_data[i], dv_mode[i], dv_off[i], dv_exp[i]);
        drain();

        out_ready = 1'b0;
        send(32'h0000_AAAA, 3'd2, 2'd0, model(32'h0000_AAAA, 3'd2, 2'd0));
        send(32'h0000_BBBB, 3'd0, 2'd0, model(32'h0000_BBBB, 3'd0, 2'd0));
        chk("bp_in_ready", in_ready, 0);
        chk("bp_occupancy", occupancy, 2);
        in_valid = 1'b1; in_data = 32'h0000_0CC0; in_mode = 3'd3; in_off = 2'd0;
        cur_exp = model(32'h0000_0CC0, 3'd3, 2'd0);
        repeat (3) step();
        chk("bp_held_ready", in_ready, 0);
        chk("bp_held_occupancy", occupancy, 2);
        out_ready = 1'b1;
        wait_ready("bp_release");
        step();
        in_valid = 1'b0;
        drain();

        p0 = pops;
        for (int i = 0; i < 20; i++) begin
            d = $urandom;
            in_valid = 1'b1; in_data = d; in_mode = 3'($urandom_range(0, 7)); in_off = 2'($urandom_range(0, 3));
            cur_exp = model(d, in_mode, in_off);
            step();
            chk("stream_occupancy", occupancy, 1);
            chk("stream_in_ready", in_ready, 1);
        end
        in_valid = 1'b0;
        step();
        chk("stream_pops", 64'(pops - p0), 20);
        chk("stream_drained", occupancy, 0);

        out_ready = 1'b0;
        send(32'h1111_2222, 3'd1, 2'd0, model(32'h1111_2222, 3'd1, 2'd0));
        send(32'h3333_4444, 3'd5, 2'd2, model(32'h3333_4444, 3'd5, 2'd2));
        in_valid = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_out_valid", out_valid, 0);
        chk("rst_mid_occupancy", occupancy, 0);
        chk("rst_mid_out_data", {out_err, out_data}, 0);
        sb.delete();
        in_valid = 1'b0;
        step(); step();
        rst_n = 1'b1;
        step();
        chk("rst_rel_in_ready", in_ready, 1);
        chk("rst_rel_out_valid", out_valid, 0);

        for (int i = 0; i < 400; i++) begin
            d = $urandom;
            in_valid = $urandom_range(0, 3) != 0;
            in_data = d; in_mode = 3'($urandom_range(0, 7)); in_off = 2'($urandom_range(0, 3));
            cur_exp = model(d, in_mode, in_off);
            out_ready = $urandom_range(0, 2) != 0;
            step();
        end
        drain();
        chk("total_pushes_pops", 64'(pushes - 2), 64'(pops));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
